// File: rtl/elbert_divider_bank_if.sv
// Bundles the control and status signals of elbert_divider_bank.
//   master : drives enable/load config, observes channel outputs and free count
//   slave  : the divider bank itself
// Signals:
//   enable    1 = all counters advance, 0 = all hold
//   load      write load_div/load_mode into channel load_ch this cycle
//   load_ch   channel index; values >= NUM_CH are ignored
//   load_div  divide value D, event period D+1 cycles
//   load_mode 00 OFF, 01 TOGGLE, 10 PULSE, 11 ONESHOT
//   ch_out    per-channel registered output
//   ch_active channel on and oneshot not yet fired
//   free_cnt  free-running count
interface elbert_divider_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 32
);
    logic              enable;
    logic              load;
    logic [CH_W-1:0]   load_ch;
    logic [DIV_W-1:0]  load_div;
    logic [1:0]        load_mode;
    logic [NUM_CH-1:0] ch_out;
    logic [NUM_CH-1:0] ch_active;
    logic [CNT_W-1:0]  free_cnt;

    modport master (
        output enable, load, load_ch, load_div, load_mode,
        input  ch_out, ch_active, free_cnt
    );

    modport slave (
        input  enable, load, load_ch, load_div, load_mode,
        output ch_out, ch_active, free_cnt
    );
endinterface

// File: rtl/elbert_divider_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers plus a free-running
// counter, all on the rising edge of clock.
// Ports:
//   clock  board clock
//   reset  synchronous, active-high; wins over a concurrent load
//   bus    elbert_divider_bank_if.slave (config in, ch_out/ch_active/free_cnt out)
// Each channel counts 0..D and raises an internal event when cnt==D, giving an
// event every D+1 enabled edges. The mode decides what the event does to
// ch_out. All outputs come straight from registers.
module elbert_divider_bank #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 32
) (
    input logic                   clock,
    input logic                   reset,
    elbert_divider_bank_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_TOGGLE  = 2'b01,
        MODE_PULSE   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    logic [DIV_W-1:0]  div_q  [NUM_CH];
    logic [DIV_W-1:0]  div_d  [NUM_CH];
    logic [DIV_W-1:0]  cnt_q  [NUM_CH];
    logic [DIV_W-1:0]  cnt_d  [NUM_CH];
    mode_e             mode_q [NUM_CH];
    mode_e             mode_d [NUM_CH];
    logic [NUM_CH-1:0] out_q, out_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] active_q, active_d;
    logic [NUM_CH-1:0] evt;
    logic [CNT_W-1:0]  free_q, free_d;

    always_comb begin
        free_d = bus.enable ? free_q + CNT_W'(1) : free_q;
        evt    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]  = div_q[i];
            mode_d[i] = mode_q[i];
            cnt_d[i]  = cnt_q[i];
            out_d[i]  = out_q[i];
            done_d[i] = done_q[i];
            // An out-of-range load_ch matches no channel and is dropped.
            if (bus.load && (bus.load_ch == CH_W'(i))) begin
                div_d[i]  = bus.load_div;
                mode_d[i] = mode_e'(bus.load_mode);
                cnt_d[i]  = '0;
                out_d[i]  = 1'b0;
                done_d[i] = 1'b0;
            end else if (mode_q[i] == MODE_OFF) begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
            end else if (bus.enable && !done_q[i]) begin
                evt[i]   = (cnt_q[i] == div_q[i]);
                cnt_d[i] = evt[i] ? '0 : cnt_q[i] + DIV_W'(1);
                case (mode_q[i])
                    MODE_TOGGLE:  if (evt[i]) out_d[i] = ~out_q[i];
                    MODE_PULSE:   out_d[i] = evt[i];
                    MODE_ONESHOT: if (evt[i]) begin
                        out_d[i]  = 1'b1;
                        done_d[i] = 1'b1;
                    end
                    default: ;
                endcase
            end
            // Built from next-state so ch_active drops on the same edge a
            // oneshot output rises.
            active_d[i] = (mode_d[i] != MODE_OFF) && !done_d[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]  <= '0;
                cnt_q[i]  <= '0;
                mode_q[i] <= MODE_OFF;
            end
            out_q    <= '0;
            done_q   <= '0;
            active_q <= '0;
            free_q   <= '0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            out_q    <= out_d;
            done_q   <= done_d;
            active_q <= active_d;
            free_q   <= free_d;
        end
    end

    assign bus.ch_out    = out_q;
    assign bus.ch_active = active_q;
    assign bus.free_cnt  = free_q;
endmodule

// File: tb/tb_elbert_divider_bank.sv
// Directed bench for elbert_divider_bank: a default build (4 channels, 32-bit
// free count) and a small build (3 channels, 4-bit free count) share one clock.
module tb_elbert_divider_bank;
    localparam logic [1:0] M_OFF = 2'b00, M_TOG = 2'b01, M_PUL = 2'b10, M_ONE = 2'b11;

    logic clk = 1'b0;
    logic rst, rst_s;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    elbert_divider_bank_if #(.NUM_CH(4), .CH_W(2), .DIV_W(16), .CNT_W(32)) bm ();
    elbert_divider_bank_if #(.NUM_CH(3), .CH_W(2), .DIV_W(16), .CNT_W(4))  bs ();

    elbert_divider_bank #(.NUM_CH(4), .CH_W(2), .DIV_W(16), .CNT_W(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bm.slave)
    );

    elbert_divider_bank #(.NUM_CH(3), .CH_W(2), .DIV_W(16), .CNT_W(4)) dut_s (
        .clock (clk),
        .reset (rst_s),
        .bus   (bs.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ld_m(input logic [1:0] ch, input logic [15:0] d, input logic [1:0] m);
        bm.load = 1'b1; bm.load_ch = ch; bm.load_div = d; bm.load_mode = m;
    endtask

    task automatic ld_s(input logic [1:0] ch, input logic [15:0] d, input logic [1:0] m);
        bs.load = 1'b1; bs.load_ch = ch; bs.load_div = d; bs.load_mode = m;
    endtask

    initial begin
        rst = 1'b1; rst_s = 1'b1;
        bm.enable = 1'b1; bm.load = 1'b0; bm.load_ch = '0; bm.load_div = '0; bm.load_mode = M_OFF;
        bs.enable = 1'b1; bs.load = 1'b0; bs.load_ch = '0; bs.load_div = '0; bs.load_mode = M_OFF;
        tick(); tick();

        // random activity, then reset held 2 cycles while a load is requested
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bm.load      = 1'($urandom_range(0, 1));
            bm.load_ch   = 2'($urandom_range(0, 3));
            bm.load_div  = 16'($urandom_range(0, 3));
            bm.load_mode = 2'($urandom_range(1, 3));
            tick();
        end
        rst = 1'b1;
        ld_m(2'd0, 16'd4, M_TOG);
        tick(); tick();
        chk("rst_ch_out", 32'(bm.ch_out), 0);
        chk("rst_ch_active", 32'(bm.ch_active), 0);
        chk("rst_free_cnt", bm.free_cnt, 0);
        rst = 1'b0; bm.load = 1'b0;
        tick();
        chk("post_rst_free_cnt", bm.free_cnt, 1);
        chk("rst_load_not_taken", 32'(bm.ch_active), 0);
        chk("post_rst_ch_out", 32'(bm.ch_out), 0);

        // ch0 TOGGLE D=4: period 10, first rise after T+5
        ld_m(2'd0, 16'd4, M_TOG);
        tick(); bm.load = 1'b0;
        chk("tog_active", 32'(bm.ch_active[0]), 1);
        chk("tog_start", 32'(bm.ch_out[0]), 0);
        for (int k = 1; k <= 100; k++) begin
            tick();
            chk("tog_wave", 32'(bm.ch_out[0]), (k / 5) % 2);
        end

        // ch1 PULSE D=2: one high cycle in three; then D=0 holds high
        ld_m(2'd1, 16'd2, M_PUL);
        tick(); bm.load = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("pulse_d2", 32'(bm.ch_out[1]), (k % 3 == 0) ? 1 : 0);
        end
        ld_m(2'd1, 16'd0, M_PUL);
        tick(); bm.load = 1'b0;
        chk("pulse_reload_clr", 32'(bm.ch_out[1]), 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("pulse_d0", 32'(bm.ch_out[1]), 1);
        end

        // ch2 ONESHOT D=7: fires after T+8 and stays
        ld_m(2'd2, 16'd7, M_ONE);
        tick(); bm.load = 1'b0;
        repeat (7) tick();
        chk("one_pre_out", 32'(bm.ch_out[2]), 0);
        chk("one_pre_act", 32'(bm.ch_active[2]), 1);
        tick();
        chk("one_fire_out", 32'(bm.ch_out[2]), 1);
        chk("one_fire_act", 32'(bm.ch_active[2]), 0);
        repeat (50) tick();
        chk("one_hold_out", 32'(bm.ch_out[2]), 1);
        chk("one_hold_act", 32'(bm.ch_active[2]), 0);
        ld_m(2'd2, 16'd7, M_ONE);
        tick(); bm.load = 1'b0;
        chk("one_reload_out", 32'(bm.ch_out[2]), 0);
        chk("one_reload_act", 32'(bm.ch_active[2]), 1);

        // ch0 D=4, enable dropped 3 edges after T+2: first rise moves to T+8
        ld_m(2'd0, 16'd4, M_TOG);
        tick(); bm.load = 1'b0;
        tick(); tick();
        bm.enable = 1'b0;
        tick(); tick(); tick();
        chk("en_hold", 32'(bm.ch_out[0]), 0);
        bm.enable = 1'b1;
        tick(); tick();
        chk("en_shift_pre", 32'(bm.ch_out[0]), 0);
        tick();
        chk("en_shift_rise", 32'(bm.ch_out[0]), 1);
        repeat (5) tick();
        chk("en_shift_fall", 32'(bm.ch_out[0]), 0);

        // small build: 4-bit free count wraps, holds while disabled
        chk("s_rst_free", 32'(bs.free_cnt), 0);
        rst_s = 1'b0;
        repeat (15) tick();
        chk("s_free_15", 32'(bs.free_cnt), 15);
        bs.enable = 1'b0;
        tick(); tick();
        chk("s_free_hold", 32'(bs.free_cnt), 15);
        bs.enable = 1'b1;
        tick();
        chk("s_free_wrap", 32'(bs.free_cnt), 0);

        // small build: invalid channel load ignored, ch0 reload restarts only ch0
        for (int e = 0; e <= 20; e++) begin
            bs.load = 1'b0;
            case (e)
                0: ld_s(2'd1, 16'd1, M_TOG);
                1: ld_s(2'd2, 16'd2, M_PUL);
                2: ld_s(2'd0, 16'd3, M_TOG);
                6: ld_s(2'd3, 16'd0, M_PUL);
                9: ld_s(2'd0, 16'd3, M_TOG);
                default: ;
            endcase
            tick();
            chk("s_ch1", 32'(bs.ch_out[1]), (e / 2) % 2);
            chk("s_ch2", 32'(bs.ch_out[2]), (e > 1 && (e - 1) % 3 == 0) ? 1 : 0);
            if (e < 2)
                chk("s_ch0", 32'(bs.ch_out[0]), 0);
            else if (e < 9)
                chk("s_ch0", 32'(bs.ch_out[0]), ((e - 2) / 4) % 2);
            else
                chk("s_ch0_restart", 32'(bs.ch_out[0]), ((e - 9) / 4) % 2);
        end
        bs.load = 1'b0;
        chk("s_active", 32'(bs.ch_active), 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
